// File: rtl/hand_dealer.sv
// Card generator plus one Baccarat hand of NUM_SLOTS cards with a registered score.
// Optional HAND_DEALER_STEP_EN adds deck_step so the generator advances only when stepped.
module hand_dealer #(
    parameter int unsigned NUM_SLOTS = 3,
    parameter int unsigned CARD_MAX  = 13
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     new_hand,
    input  logic                     deal,
`ifdef HAND_DEALER_STEP_EN
    input  logic                     deck_step,
`endif
    output logic [4*NUM_SLOTS-1:0]   cards,
    output logic [3:0]               next_card,
    output logic [1:0]               num_cards,
    output logic                     full,
    output logic [3:0]               score,
    output logic                     score_valid,
    output logic                     overflow
);

    logic [3:0] slot_q [NUM_SLOTS];
    logic [3:0] slot_d [NUM_SLOTS];
    logic [3:0] next_card_q, next_card_d;
    logic [1:0] num_cards_q, num_cards_d;
    logic [3:0] score_q, score_d;
    logic       score_valid_q, score_valid_d;
    logic       overflow_q, overflow_d;
    logic       advance;
    logic       full_w;
    logic [4:0] sum;

    always_comb begin
`ifdef HAND_DEALER_STEP_EN
        advance = deck_step;
`else
        advance = 1'b1;
`endif
        next_card_d = next_card_q;
        if (advance) begin
            if (next_card_q >= 4'(CARD_MAX)) begin
                next_card_d = 4'd1;
            end else begin
                next_card_d = next_card_q + 4'd1;
            end
        end

        full_w = (num_cards_q == 2'(NUM_SLOTS));

        // Face cards and empty slots contribute nothing; sum is at most 27.
        sum = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (slot_q[i] <= 4'd9) begin
                sum = sum + 5'(slot_q[i]);
            end
        end
        if (sum >= 5'd20) begin
            score_d = 4'(sum - 5'd20);
        end else if (sum >= 5'd10) begin
            score_d = 4'(sum - 5'd10);
        end else begin
            score_d = 4'(sum);
        end

        slot_d        = slot_q;
        num_cards_d   = num_cards_q;
        overflow_d    = overflow_q;
        score_valid_d = 1'b1;

        if (new_hand) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slot_d[i] = '0;
            end
            num_cards_d   = '0;
            overflow_d    = 1'b0;
            score_d       = '0;
            score_valid_d = 1'b1;
        end else if (deal) begin
            if (full_w) begin
                overflow_d = 1'b1;
            end else begin
                for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                    if (num_cards_q == 2'(i)) begin
                        slot_d[i] = next_card_q;
                    end
                end
                num_cards_d   = num_cards_q + 2'd1;
                score_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            next_card_q   <= 4'd1;
            num_cards_q   <= '0;
            score_q       <= '0;
            score_valid_q <= 1'b1;
            overflow_q    <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            next_card_q   <= next_card_d;
            num_cards_q   <= num_cards_d;
            score_q       <= score_d;
            score_valid_q <= score_valid_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        cards = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            cards[4*i +: 4] = slot_q[i];
        end
    end

    assign next_card   = next_card_q;
    assign num_cards   = num_cards_q;
    assign full        = full_w;
    assign score       = score_q;
    assign score_valid = score_valid_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/hand_dealer.md
Name: hand_dealer

Overview:
- Upstream stage of the per-card seven-segment decoders in the Baccarat datapath.
- Contains the card generator, which produces values 1..13.
- Holds one hand of up to NUM_SLOTS dealt cards. Each slot drives one 4-bit card code to a display decoder; code 0 means an empty slot and is shown blank.
- Produces the registered Baccarat hand score, which the scoring/FSM stage consumes.

Parameters:
- NUM_SLOTS, 3, number of card slots in the hand (legal 1..3).
- CARD_MAX, 13, highest card code produced by the generator (King).

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- new_hand  in  1  one-cycle pulse; clears all slots and the score.
- deal  in  1  one-cycle pulse; loads the current generator value into the next empty slot.
- cards  out  4*NUM_SLOTS  packed slot codes; slot 0 in bits [3:0]. Codes: 0 empty, 1 Ace .. 13 King.
- next_card  out  4  current generator value (1..CARD_MAX).
- num_cards  out  2  count of filled slots (0..NUM_SLOTS).
- full  out  1  high when num_cards == NUM_SLOTS.
- score  out  4  registered hand score, 0..9.
- score_valid  out  1  high when score reflects the current slot contents.
- overflow  out  1  sticky; set by a deal attempted while full.

Behaviour:
- Reset values, applied asynchronously on reset=1: next_card=1, all slots 0, num_cards=0, full=0, score=0, score_valid=1, overflow=0.
- Generator:
  - Free-running; advances every clock: 1,2,..,CARD_MAX,1.
  - Wrap: CARD_MAX -> 1. Value 0 is never produced.
- Deal:
  - Sampled at the rising edge when deal=1 and full=0.
  - slot[num_cards] <= next_card, using the pre-advance value at that edge.
  - num_cards increments; score_valid <= 0 at the same edge.
- Deal while full: slots and num_cards are unchanged; overflow <= 1.
- overflow clears only on new_hand or reset.
- new_hand:
  - At the edge: all slots <= 0, num_cards <= 0, overflow <= 0, score <= 0, score_valid <= 1.
  - The generator is not affected.
- new_hand and deal in the same cycle: new_hand wins; the deal is dropped and overflow is not set.
- Score:
  - Card value: 1..9 count face value; 10..13 count 0; empty counts 0.
  - Sum over slots is at most 27; score = sum mod 10. Compute the mod with compare/subtract; no divider.
  - Score register latency is one clock after the slot write. score_valid returns to 1 on that edge.
  - Back-to-back deals on consecutive cycles: each edge recomputes from the latest slots. score_valid stays 0 until one idle cycle follows the last deal.
- deal/new_hand held high for several cycles act once per edge; upstream must pulse them.
- Reset mid-hand: immediate asynchronous clear to reset values, independent of clock.

Optional Feature:
- Macro: HAND_DEALER_STEP_EN.
- Defined:
  - Extra input port deck_step (1 bit) is added after deal.
  - The generator advances only on edges where deck_step=1; otherwise it holds its value.
  - Gives the bench deterministic card values.
- Undefined: no deck_step port; the generator free-runs every clock as described above.

Test Plan:
- Reset, then 14 clocks with no deal -> next_card reads 1,2,..,13,1. All cards 0; score 0; score_valid 1.
- Deal pulses when next_card is 7, then 5 (STEP_EN hold) -> slot0=7, slot1=5, num_cards=2. score goes 7, then (7+5) mod 10 = 2, each one clock after its write.
- Deal when next_card is 12, 10, 13 -> slots 12,10,13; full=1; score=0 (face cards count 0).
- Deal 9, 9, 8; then a 4th deal -> slots unchanged; score (9+9+8) mod 10 = 6; overflow=1. A following new_hand clears everything and overflow=0.
- new_hand and deal asserted together with num_cards=1 -> all slots 0, num_cards=0, overflow=0.
- Assert reset mid-clock-period with 2 cards held -> outputs clear before the next edge; next_card=1.
